// File: rtl/aes_inv_cipher_iter_pkg.sv
// aes_inv_cipher_iter_pkg: AES-128 inverse-cipher types, inverse S-box table and GF(2^8)/InvShiftRows helpers
package aes_inv_cipher_iter_pkg;
  localparam int AES_NUM_ROUNDS = 10;
  typedef logic [0:15][7:0] state_t;
  typedef logic [0:15][7:0] roundKey_t;
  typedef logic [3:0] roundIdx_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} invCipherState_t;
  localparam logic [0:15][0:15][7:0] invSbox = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };
  function automatic logic [7:0] gfMul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic state_t invShiftRows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[{2'(c), 2'(r)}] = s[{2'(c - r), 2'(r)}];
    return o;
  endfunction
endpackage

// File: rtl/aes_inv_cipher_iter_if.sv
// aes_inv_cipher_iter_if: block handshake, key-store and status signals of the inverse cipher
interface aes_inv_cipher_iter_if;
  import aes_inv_cipher_iter_pkg::*;
  logic inValid, inReady, outValid, outReady, busy;
  state_t inData, outData;
  roundIdx_t keyRound;
  roundKey_t roundKey;
  modport master(output inValid, inData, roundKey, outReady, input inReady, keyRound, outValid, outData, busy);
  modport slave(input inValid, inData, roundKey, outReady, output inReady, keyRound, outValid, outData, busy);
endinterface

// File: rtl/aes_inv_cipher_iter_round.sv
// aes_inv_round: combinational inverse round (InvShiftRows, InvSubBytes tap, AddRoundKey, optional InvMixColumns)
module aes_inv_round
  import aes_inv_cipher_iter_pkg::*;
(
  input  state_t    state_in,
  input  roundKey_t roundKey,
  input  logic      isFinal,
  input  state_t    mid_in,
  output state_t    mid,
  output state_t    state_out
);
  localparam logic [0:3][3:0] MIX = {4'he, 4'hb, 4'hd, 4'h9};
  state_t shifted, ark, mixed;
  function automatic logic [7:0] gf_mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = gfMul2(b);
    x4 = gfMul2(x2);
    x8 = gfMul2(x4);
    return ({8{c[0]}} & b) ^ ({8{c[1]}} & x2) ^ ({8{c[2]}} & x4) ^ ({8{c[3]}} & x8);
  endfunction
  always_comb begin
    shifted = invShiftRows(state_in);
    for (int i = 0; i < 16; i++) mid[4'(i)] = invSbox[shifted[4'(i)][7:4]][shifted[4'(i)][3:0]];
  end
  always_comb begin
    ark = mid_in ^ roundKey;
    mixed = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          mixed[{2'(c), 2'(r)}] ^= gf_mul(ark[{2'(c), 2'(k)}], MIX[2'(k - r)]);
    state_out = isFinal ? ark : mixed;
  end
endmodule

// File: rtl/aes_inv_cipher_iter.sv
// aes_inv_cipher_iter: iterative AES-128 inverse cipher, one round per clock (two with AES_INV_ROUND_SPLIT_EN)
module aes_inv_cipher_iter
  import aes_inv_cipher_iter_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS
) (
  input logic clock,
  input logic reset,
  aes_inv_cipher_iter_if.slave bus
);
  invCipherState_t st_q, st_d;
  roundIdx_t cnt_q, cnt_d;
  state_t state_q, state_d, out_q, out_d, mid_o, mid_i, rnd_o;
  logic step;
  aes_inv_round u_round (
    .state_in (state_q),
    .roundKey (bus.roundKey),
    .isFinal  (st_q == FINAL),
    .mid_in   (mid_i),
    .mid      (mid_o),
    .state_out(rnd_o)
  );
`ifdef AES_INV_ROUND_SPLIT_EN
  state_t mid_q, mid_d;
  logic ph_q, ph_d;
  always_comb begin
    mid_d = mid_o;
    ph_d = (st_q == ROUND || st_q == FINAL) ? ~ph_q : 1'b0;
  end
  always_ff @(posedge clock)
    if (reset) begin
      mid_q <= '0;
      ph_q <= 1'b0;
    end else begin
      mid_q <= mid_d;
      ph_q <= ph_d;
    end
  assign mid_i = mid_q;
  assign step = ph_q;
`else
  assign mid_i = mid_o;
  assign step = 1'b1;
`endif
  always_comb begin
    st_d = st_q;
    cnt_d = cnt_q;
    state_d = state_q;
    out_d = out_q;
    case (st_q)
      IDLE: if (bus.inValid) begin
        state_d = bus.inData ^ bus.roundKey;
        cnt_d = 4'(NUM_ROUNDS - 1);
        st_d = ROUND;
      end
      ROUND: if (step) begin
        state_d = rnd_o;
        cnt_d = cnt_q - 4'd1;
        st_d = (cnt_q == 4'd1) ? FINAL : ROUND;
      end
      FINAL: if (step) begin
        out_d = rnd_o;
        st_d = DONE;
      end
      DONE: if (bus.outReady) begin
        cnt_d = 4'(NUM_ROUNDS);
        st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end
  always_ff @(posedge clock)
    if (reset) begin
      st_q <= IDLE;
      cnt_q <= 4'(NUM_ROUNDS);
      state_q <= '0;
      out_q <= '0;
    end else begin
      st_q <= st_d;
      cnt_q <= cnt_d;
      state_q <= state_d;
      out_q <= out_d;
    end
  assign bus.inReady = st_q == IDLE;
  assign bus.outValid = st_q == DONE;
  assign bus.busy = st_q != IDLE;
  assign bus.keyRound = cnt_q;
  assign bus.outData = out_q;
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// tb_aes_inv_cipher_iter: FIPS-197 vectors, backpressure, mid-block reset and random back-to-back blocks against a forward-cipher model
module tb_aes_inv_cipher_iter;
  import aes_inv_cipher_iter_pkg::*;
`ifdef AES_INV_ROUND_SPLIT_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int LAT = 10 * S + 1;
  localparam int PERIOD = LAT + 1;
  localparam state_t C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam state_t C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam state_t C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam state_t B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam state_t B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam state_t B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int passed = 0;
  int total = 0;
  int cyc = 0;
  logic [7:0] sb [256];
  state_t rk [16];
  state_t pts [20];
  state_t cts [20];
  aes_inv_cipher_iter_if bus();
  aes_inv_cipher_iter #(.NUM_ROUNDS(10)) dut (.clock(clock), .reset(reset), .bus(bus));
  assign bus.roundKey = rk[bus.keyRound];
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t reached, required finish before 1000000", $time);
    $fatal(1, "watchdog expired");
  end
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = b >> 1;
    end
    return p;
  endfunction
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask
  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    for (int r = 0; r < 11; r++) rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask
  function automatic state_t encrypt(input state_t pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    state_t o;
    for (int i = 0; i < 16; i++) s[i] = pt[i] ^ rk[0][i];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int i = 0; i < 16; i++) t[i] = sb[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) s[4 * c + r] = t[4 * ((c + r) % 4) + r];
      if (rd < 10)
        for (int c = 0; c < 4; c++) begin
          a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
          s[4 * c]     = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4 * c + 1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4 * c + 2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4 * c + 3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      for (int i = 0; i < 16; i++) s[i] ^= rk[rd][i];
    end
    for (int i = 0; i < 16; i++) o[i] = s[i];
    return o;
  endfunction
  function automatic int exp_key(input int k);
    int j;
    j = (k - 1) / S;
    return j < 9 ? 9 - j : 0;
  endfunction
  function automatic state_t rand_block();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic run_block(input string tag, input state_t ct, input state_t pt, input bit chk_keys);
    int lat;
    bus.inValid = 1'b1;
    bus.inData = ct;
    check({tag, "_inready"}, bus.inReady, 1);
    if (chk_keys) check({tag, "_key_idle"}, bus.keyRound, 10);
    @(negedge clock);
    bus.inValid = 1'b0;
    bus.inData = rand_block();
    check({tag, "_busy"}, bus.busy, 1);
    lat = 1;
    while (!bus.outValid && lat < 4 * LAT) begin
      if (chk_keys) check($sformatf("%s_key_c%0d", tag, lat), bus.keyRound, exp_key(lat));
      @(negedge clock);
      lat++;
    end
    check({tag, "_latency"}, lat, LAT);
    check({tag, "_out"}, bus.outData, pt);
  endtask
  initial begin
    int n_in, n_out, last_acc;
    state_t pt, held;
    bus.inValid = 1'b0;
    bus.inData = '0;
    bus.outReady = 1'b1;
    for (int r = 0; r < 16; r++) rk[r] = '0;
    build_sbox();
    repeat (2) @(negedge clock);
    check("rst_inready", bus.inReady, 1);
    check("rst_outvalid", bus.outValid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_outdata", bus.outData, 0);
    check("rst_keyround", bus.keyRound, 10);
    reset = 1'b0;
    expand_key(C1_KEY);
    run_block("c1", C1_CT, C1_PT, 1'b1);
    @(negedge clock);
    check("c1_idle_busy", bus.busy, 0);
    expand_key(B_KEY);
    bus.outReady = 1'b0;
    run_block("fipsb", B_CT, B_PT, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.inValid = (i % 2) == 0;
      bus.inData = rand_block();
      check($sformatf("bp_valid%0d", i), bus.outValid, 1);
      check($sformatf("bp_data%0d", i), bus.outData, B_PT);
      check($sformatf("bp_inready%0d", i), bus.inReady, 0);
      @(negedge clock);
    end
    bus.inValid = 1'b0;
    bus.outReady = 1'b1;
    check("bp_release_valid", bus.outValid, 1);
    @(negedge clock);
    check("bp_after_inready", bus.inReady, 1);
    check("bp_after_outvalid", bus.outValid, 0);
    check("bp_after_busy", bus.busy, 0);
    pt = rand_block();
    run_block("bp_next", encrypt(pt), pt, 1'b0);
    @(negedge clock);
    expand_key(C1_KEY);
    bus.inValid = 1'b1;
    bus.inData = C1_CT;
    @(negedge clock);
    bus.inValid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_inready", bus.inReady, 1);
    check("mid_rst_outvalid", bus.outValid, 0);
    check("mid_rst_outdata", bus.outData, 0);
    check("mid_rst_keyround", bus.keyRound, 10);
    check("mid_rst_busy", bus.busy, 0);
    reset = 1'b0;
    run_block("c1_after_rst", C1_CT, C1_PT, 1'b1);
    @(negedge clock);
    expand_key(rand_block());
    for (int i = 0; i < 20; i++) begin
      pts[i] = rand_block();
      cts[i] = encrypt(pts[i]);
    end
    n_in = 0;
    n_out = 0;
    last_acc = -1;
    held = '0;
    bus.inValid = 1'b1;
    for (int t = 0; t < 20 * PERIOD + 50 && n_out < 20; t++) begin
      if (bus.outValid) begin
        check($sformatf("b2b_out%0d", n_out), bus.outData, pts[n_out]);
        n_out++;
      end
      if (bus.inReady) begin
        if (n_in < 20) begin
          held = cts[n_in];
          if (last_acc >= 0) check($sformatf("b2b_period%0d", n_in), cyc - last_acc, PERIOD);
          last_acc = cyc;
          n_in++;
        end else bus.inValid = 1'b0;
      end
      bus.inData = held;
      @(negedge clock);
    end
    bus.inValid = 1'b0;
    check("b2b_count", n_out, 20);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
